axi4_lite_read_slave: RTL and testbench
=======================================

Name: axi4_lite_read_slave

Overview:
- AXI4-lite read responder; the slave-side counterpart of the team's AXI4-lite read master.
- Accepts one read address at a time and range/alignment-checks it.
- Fetches the word from a simple variable-latency backend (BRAM, register file or peripheral) and returns it on the R channel with a response code.
- Sits between the interconnect and memory-mapped peripherals or data memory in the benchmarking SoC.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; word = DATA_WIDTH/8 bytes.
- BASE_ADDR, 32'h0000_0000, first byte address decoded by this slave.
- MEM_SIZE, 4096, decoded window size in bytes; power of two, ≥ word size.
- TIMEOUT_CYCLES, 256, backend wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARVALID  in  1  address valid
- S_AXI_ARREADY  out  1  slave accepts address
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  master accepts data
- mem_rd_req  out  1  backend read request; held until ack
- mem_rd_addr  out  ADDR_WIDTH  byte offset (ARADDR - BASE_ADDR)
- mem_rd_ack  in  1  backend data valid; single-cycle pulse
- mem_rd_data  in  DATA_WIDTH  backend read data, valid with ack

Behaviour:
- Clock and reset: single clock domain; rst asynchronous, active-high.
- Reset values: S_AXI_ARREADY=0, S_AXI_RVALID=0, S_AXI_RDATA=0, S_AXI_RRESP=00, mem_rd_req=0, mem_rd_addr=0, internal address/data/resp registers 0, state ST_IDLE.
- Reset mid-transaction: aborts immediately; no response is issued for the aborted read; a late mem_rd_ack after reset is ignored.
- States:
  - ST_IDLE: ARREADY=1.
  - ST_MEM_REQ: mem_rd_req=1.
  - ST_RESP: RVALID=1.
- ST_IDLE: on ARVALID&ARREADY, latch ARADDR and decode it:
  - ARADDR < BASE_ADDR or ≥ BASE_ADDR+MEM_SIZE -> resp=11, data=0, go ST_RESP.
  - In range with ARADDR[log2(DATA_WIDTH/8)-1:0] ≠ 0 -> resp=10, data=0, go ST_RESP.
  - Otherwise -> go ST_MEM_REQ.
  - Range compare uses ADDR_WIDTH+1-bit arithmetic so BASE_ADDR+MEM_SIZE cannot wrap.
- ST_MEM_REQ:
  - mem_rd_req=1; mem_rd_addr = latched address minus BASE_ADDR, stable while req is high.
  - On mem_rd_ack, latch mem_rd_data, set resp=00, go ST_RESP. mem_rd_req drops the cycle after ack.
  - mem_rd_ack outside ST_MEM_REQ is ignored.
- ST_RESP:
  - RVALID=1; RDATA/RRESP are registered and stable while RVALID=1.
  - On RREADY go ST_IDLE. RVALID never drops without RREADY.
  - RREADY is permitted to be high before RVALID.
- Handshake rules:
  - ARREADY is 1 only in ST_IDLE: one outstanding read, no AR acceptance while a response is pending.
  - ARADDR is sampled only on the handshake cycle.
- Latency:
  - Error response: RVALID asserted 1 cycle after the AR handshake.
  - Good response: RVALID asserted 1 cycle after mem_rd_ack. With a zero-wait backend (ack in the first req cycle), RVALID is asserted 2 cycles after the AR handshake.
  - Back-to-back throughput: one read per 3 cycles minimum (AR, REQ, RESP).
- Outputs are decoded from the registered state only; no combinational path from ARVALID or RREADY to any output.

Optional Feature:
- Macro AXI4_LITE_READ_SLAVE_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ST_MEM_REQ and increments each cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: drop mem_rd_req, set resp=10, data=0, go ST_RESP.
  - Ack in the same cycle as the timeout wins (OKAY with data).
- Undefined: no counter; ST_MEM_REQ waits indefinitely for ack.

Test Plan:
- BASE_ADDR=0x1000, MEM_SIZE=4096: AR 0x1010, backend acks 0 cycles later with 0xDEADBEEF, RREADY=1 -> mem_rd_addr=0x010, RVALID 2 cycles after handshake, RDATA=0xDEADBEEF, RRESP=00.
- AR 0x3000 and AR 0x0FFC -> RRESP=11, RDATA=0, RVALID 1 cycle after handshake, mem_rd_req never asserts.
- AR 0x1002 -> RRESP=10, RDATA=0, no backend request.
- Backend ack delayed 5 cycles, RREADY held low 4 cycles after RVALID -> mem_rd_req high 5 cycles, RVALID/RDATA/RRESP stable until RREADY, ARREADY=0 throughout, ARVALID for next address waits.
- Assert rst while in ST_MEM_REQ and again in ST_RESP -> all outputs 0 asynchronously, ack pulse after reset ignored, next AR 0x1004 completes normally.
- With AXI4_LITE_READ_SLAVE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> req drops after 8 cycles, RRESP=10, RDATA=0; ack exactly at cycle 8 -> RRESP=00 with data.

Source files
------------

// File: rtl/axi4_lite_read_slave.sv
// rtl/axi4_lite_read_slave.sv - AXI4-lite read slave with address decode and variable-latency backend
//
// Purpose: accepts one AR request at a time, range/alignment-checks it, fetches
// the word from a request/ack backend and returns it on the R channel.
// Optional feature macro: AXI4_LITE_READ_SLAVE_TIMEOUT_EN (backend wait limit of
// TIMEOUT_CYCLES; on expiry the read completes with SLVERR).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   S_AXI_AR*       read address channel (ARADDR, ARVALID, ARREADY)
//   S_AXI_R*        read data channel (RDATA, RRESP, RVALID, RREADY)
//   mem_rd_req      backend request, held until mem_rd_ack
//   mem_rd_addr     byte offset into the decoded window (ARADDR - BASE_ADDR)
//   mem_rd_ack      single-cycle backend completion pulse
//   mem_rd_data     backend data, valid with mem_rd_ack
module axi4_lite_read_slave #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned            MEM_SIZE       = 4096,
  parameter int unsigned            TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ack,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int unsigned           WORD_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(WORD_BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   BASE_EXT   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0]   SIZE_EXT   = (ADDR_WIDTH + 1)'(MEM_SIZE);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEM_REQ = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  ready_en;
  logic [ADDR_WIDTH-1:0] off_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  // Offset computed in ADDR_WIDTH+1 bits: the top bit is the borrow of
  // ARADDR - BASE_ADDR, so "below base" and "past the window" fall out of one
  // subtract and BASE_ADDR + MEM_SIZE can never wrap.
  logic [ADDR_WIDTH:0] ar_off;
  logic                in_range;
  logic                misaligned;
  logic                ar_fire;
  logic                timed_out;

  assign ar_off     = {1'b0, S_AXI_ARADDR} - BASE_EXT;
  assign in_range   = !ar_off[ADDR_WIDTH] && (ar_off < SIZE_EXT);
  assign misaligned = (S_AXI_ARADDR & ALIGN_MASK) != '0;
  assign ar_fire    = S_AXI_ARVALID && S_AXI_ARREADY;

`ifdef AXI4_LITE_READ_SLAVE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  // Counter holds at zero outside ST_MEM_REQ, so it is clear on entry. The
  // timeout fires in the cycle the count would reach TIMEOUT_CYCLES; an ack
  // in that same cycle takes priority.
  assign timed_out = (state == ST_MEM_REQ) && !mem_rd_ack &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != ST_MEM_REQ) begin
      to_cnt <= '0;
    end else if (!mem_rd_ack) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timed_out             = 1'b0;
`endif

  // State register. ready_en keeps ARREADY low while reset is held and for
  // the first cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= next_state;
      ready_en <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (ar_fire) begin
          next_state = (in_range && !misaligned) ? ST_MEM_REQ : ST_RESP;
        end
      end
      ST_MEM_REQ: begin
        if (mem_rd_ack || timed_out) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (S_AXI_RREADY) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    S_AXI_ARREADY = (state == ST_IDLE) && ready_en;
    S_AXI_RVALID  = (state == ST_RESP);
    mem_rd_req    = (state == ST_MEM_REQ);
    mem_rd_addr   = off_q;
    S_AXI_RDATA   = rdata_q;
    S_AXI_RRESP   = rresp_q;
  end

  // Address/response datapath. Nothing here changes in ST_RESP, which keeps
  // RDATA/RRESP stable until the R handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_fire) begin
            if (!in_range) begin
              rdata_q <= '0;
              rresp_q <= RESP_DECERR;
            end else if (misaligned) begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end else begin
              off_q <= ar_off[ADDR_WIDTH-1:0];
            end
          end
        end
        ST_MEM_REQ: begin
          if (mem_rd_ack) begin
            rdata_q <= mem_rd_data;
            rresp_q <= RESP_OKAY;
          end else if (timed_out) begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// tb/tb_axi4_lite_read_slave.sv - scoreboard testbench for axi4_lite_read_slave
`timescale 1ns/1ps
module tb_axi4_lite_read_slave;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          SIZE = 4096;
  localparam int          TO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_ack;
  logic [DW-1:0] mem_rd_data;

  axi4_lite_read_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
    .MEM_SIZE(SIZE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [0:1023];
  bit          be_auto  = 1'b0;
  int          be_wait  = 0;
  int          be_cnt   = 0;
  bit          in_abort = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_data;
  logic [1:0]  stall_resp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Backend model: acks in the (be_wait+1)-th cycle of a request.
  initial begin
    mem_rd_ack  = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (be_auto) begin
        mem_rd_ack = 1'b0;
        if (mem_rd_req) begin
          if (be_cnt >= be_wait) begin
            mem_rd_ack  = 1'b1;
            mem_rd_data = mem[mem_rd_addr[11:2]];
            be_cnt      = 0;
          end else begin
            be_cnt++;
          end
        end else begin
          be_cnt = 0;
        end
      end
    end
  end

  // R channel monitor: pops the scoreboard on each handshake, checks stability
  // while stalled and that no AR is accepted while a read is outstanding.
  always @(negedge clk) begin
    if (!rst && !in_abort) begin
      if (stall_prev) begin
        check("rvalid_hold", rvalid, 1);
        check("rdata_stable", rdata, stall_data);
        check("rresp_stable", rresp, stall_resp);
      end
      check("arready_excl", arready && (rvalid || mem_rd_req), 0);
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_r", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rdata", rdata, mon_e.data);
          check("rresp", rresp, mon_e.resp);
        end
      end
      stall_prev = rvalid && !rready;
      stall_data = rdata;
      stall_resp = rresp;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic ar_handshake(input logic [31:0] addr, output bit ok);
    int n;
    n       = 0;
    ok      = 1'b0;
    araddr  = addr;
    arvalid = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (arready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) check("arready_timeout", 0, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    araddr  = 32'hFFFF_FFF0;
  endtask

  // ack_wait < 0 means the backend never acks (timeout build only).
  task automatic do_read(input logic [31:0] addr, input int ack_wait,
                         input int rdy_delay, input bit keep_next);
    exp_t        e;
    int          exp_lat, exp_req, lat, nreq;
    bit          ok;
    logic [31:0] off;
    off = addr - BASE;
    if (addr < BASE || addr >= BASE + SIZE) begin
      e.data = 32'h0; e.resp = 2'b11; exp_lat = 1; exp_req = 0;
    end else if (addr[1:0] != 2'b00) begin
      e.data = 32'h0; e.resp = 2'b10; exp_lat = 1; exp_req = 0;
    end else if (ack_wait < 0) begin
      e.data = 32'h0; e.resp = 2'b10; exp_lat = TO + 1; exp_req = TO;
    end else begin
      e.data = mem[off[11:2]]; e.resp = 2'b00;
      exp_lat = ack_wait + 2; exp_req = ack_wait + 1;
    end
    be_wait = ack_wait;
    be_auto = (ack_wait >= 0);
    rready  = (rdy_delay == 0);
    exp_q.push_back(e);
    ar_handshake(addr, ok);
    if (keep_next) begin
      arvalid = 1'b1;
      araddr  = 32'h0000_1020;
    end
    lat  = 0;
    nreq = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_rd_req) begin
        nreq++;
        check("mem_rd_addr", mem_rd_addr, off);
      end
    end while (!rvalid && lat < 60);
    check("r_latency", lat, exp_lat);
    check("req_cycles", nreq, exp_req);
    for (int k = 0; k < rdy_delay; k++) begin
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_drop", rvalid, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rresp"}, rresp, 0);
    check({tag, "_req"}, mem_rd_req, 0);
    check({tag, "_addr"}, mem_rd_addr, 0);
  endtask

  initial begin
    bit          ok;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[4]  = 32'hDEAD_BEEF;
    rst     = 1'b1;
    arvalid = 1'b0;
    araddr  = '0;
    rready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_read(32'h0000_1010, 0, 0, 1'b0);
    do_read(32'h0000_3000, 0, 0, 1'b0);
    do_read(32'h0000_0FFC, 0, 0, 1'b0);
    do_read(32'h0000_1002, 0, 0, 1'b0);
    do_read(32'h0000_2000, 0, 0, 1'b0);
    do_read(32'h0000_1FFC, 2, 1, 1'b0);
    do_read(32'h0000_1000, 0, 2, 1'b0);
    do_read(32'h0000_1040, 4, 4, 1'b1);
    do_read(32'h0000_1020, 1, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a = BASE + ($urandom_range(0, 1023) << 2);
      do_read(a, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    // Reset while waiting on the backend, then a late ack.
    in_abort = 1'b1;
    be_auto  = 1'b0;
    @(posedge clk); #1;
    mem_rd_ack = 1'b0;
    ar_handshake(32'h0000_1010, ok);
    @(negedge clk);
    check("abort_req_on", mem_rd_req, 1);
    #2 rst = 1'b1;
    #1 check_zero_outputs("abort_req");
    @(posedge clk); #1;
    rst         = 1'b0;
    mem_rd_ack  = 1'b1;
    mem_rd_data = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_rd_ack  = 1'b0;
    check("late_ack_rvalid", rvalid, 0);
    check("late_ack_req", mem_rd_req, 0);
    check("late_ack_rdata", rdata, 0);
    @(negedge clk);
    check("late_ack_rvalid2", rvalid, 0);

    // Reset while a response is pending.
    @(posedge clk); #1;
    rready = 1'b0;
    ar_handshake(32'h0000_3000, ok);
    @(negedge clk);
    check("abort_rvalid_on", rvalid, 1);
    #2 rst = 1'b1;
    #1 check_zero_outputs("abort_resp");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    in_abort = 1'b0;
    do_read(32'h0000_1004, 0, 0, 1'b0);

`ifdef AXI4_LITE_READ_SLAVE_TIMEOUT_EN
    do_read(32'h0000_1100, -1, 0, 1'b0);
    do_read(32'h0000_1104, TO - 1, 0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
